// File: rtl/cr_kme_stall_fifo.sv
// Single-clock valid/ack FIFO with programmable early stall, flush, occupancy/high-water
// reporting and an optional registered head stage that counts toward the capacity.
module cr_kme_stall_fifo #(
    parameter int DATA_SIZE   = 611,
    parameter int FIFO_DEPTH  = 4,
    parameter int STALL_AT    = 0,
    parameter int OVERRIDE_EN = 1,
    parameter int OUT_REG     = 0,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] fifo_in,
    input  logic                 fifo_in_valid,
    output logic                 fifo_in_stall,
    input  logic                 fifo_in_stall_override,
    input  logic                 fifo_clear,
    output logic [DATA_SIZE-1:0] fifo_out,
    output logic                 fifo_out_valid,
    input  logic                 fifo_out_ack,
    output logic [CW-1:0]        fifo_used_slots,
    output logic [CW-1:0]        fifo_free_slots,
    output logic [CW-1:0]        fifo_hwm,
    output logic                 fifo_overflow,
    output logic                 fifo_underflow
);

    // The head register holds one entry, so the array only needs the remainder.
    localparam int AD = FIFO_DEPTH - OUT_REG;
    localparam int PW = (AD > 1) ? $clog2(AD) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [DATA_SIZE-1:0] mem [AD];
    logic [DATA_SIZE-1:0] arr_head;
    logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]        used_reg, used_next, hwm_reg;
    logic                 ovf_reg, udf_reg;
    logic                 head_valid, push, pop, arr_wr, arr_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(AD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign arr_head  = mem[rd_ptr_reg];
    assign pop       = head_valid & fifo_out_ack;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push      = fifo_in_valid & ((used_reg != DEPTH_C) | pop);
    assign used_next = used_reg + CW'(push) - CW'(pop);

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_SIZE-1:0] out_data_reg;
            logic                 out_valid_reg;
            logic                 head_free, arr_empty;

            assign arr_empty = (used_reg == CW'(out_valid_reg));
            assign head_free = ~out_valid_reg | pop;
            assign arr_rd    = head_free & ~arr_empty;
            // With nothing queued behind the head, the incoming word bypasses the array.
            assign arr_wr    = push & ~(head_free & arr_empty);

            always_ff @(posedge clk) begin
                if (!rst_n || fifo_clear) begin
                    out_data_reg  <= '0;
                    out_valid_reg <= 1'b0;
                end else if (head_free) begin
                    if (!arr_empty) begin
                        out_data_reg  <= arr_head;
                        out_valid_reg <= 1'b1;
                    end else if (push) begin
                        out_data_reg  <= fifo_in;
                        out_valid_reg <= 1'b1;
                    end else begin
                        out_valid_reg <= 1'b0;
                    end
                end
            end

            assign head_valid = out_valid_reg;
            assign fifo_out   = out_data_reg;
        end else begin : g_comb_out
            assign head_valid = (used_reg != '0);
            assign arr_rd     = pop;
            assign arr_wr     = push;
            assign fifo_out   = head_valid ? arr_head : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (arr_wr && rst_n && !fifo_clear) begin
            mem[wr_ptr_reg] <= fifo_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || fifo_clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            used_reg   <= '0;
            hwm_reg    <= '0;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            if (arr_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (arr_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            used_reg <= used_next;
            hwm_reg  <= (used_next > hwm_reg) ? used_next : hwm_reg;
            ovf_reg  <= fifo_in_valid & ~push;
            udf_reg  <= fifo_out_ack & ~head_valid;
        end
    end

    assign fifo_out_valid  = head_valid;
    assign fifo_used_slots = used_reg;
    assign fifo_free_slots = DEPTH_C - used_reg;
    assign fifo_hwm        = hwm_reg;
    assign fifo_overflow   = ovf_reg;
    assign fifo_underflow  = udf_reg;
    // Widened compare so STALL_AT near the top of the range cannot wrap.
    assign fifo_in_stall   = ({1'b0, fifo_free_slots} <= (CW + 1)'(STALL_AT))
                           | ((OVERRIDE_EN != 0) & fifo_in_stall_override);

endmodule

// File: tb/tb_cr_kme_stall_fifo.sv
// Three differently configured FIFOs driven with shared stimulus; each checked every cycle
// against a queue model built from the occupancy/order rules.
module tb_cr_kme_stall_fifo;

    localparam int DW = 611;
    localparam int NI = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_in = '0;
    logic          fifo_in_valid = 1'b0;
    logic          fifo_in_stall_override = 1'b0;
    logic          fifo_clear = 1'b0;
    logic          fifo_out_ack = 1'b0;

    logic [DW-1:0] dout [NI];
    logic          dval [NI];
    logic          stall [NI];
    logic [CW-1:0] used [NI];
    logic [CW-1:0] free [NI];
    logic [CW-1:0] hwm [NI];
    logic          ovf [NI];
    logic          udf [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int D = (gi == 0) ? 4 : (gi == 1) ? 5 : 6;
            localparam int S = (gi == 0) ? 0 : (gi == 1) ? 2 : 1;
            localparam int O = (gi == 1) ? 0 : 1;
            localparam int R = (gi == 0) ? 0 : 1;
            cr_kme_stall_fifo #(
                .DATA_SIZE(DW), .FIFO_DEPTH(D), .STALL_AT(S), .OVERRIDE_EN(O), .OUT_REG(R)
            ) u_dut (
                .clk                    (clk),
                .rst_n                  (rst_n),
                .fifo_in                (fifo_in),
                .fifo_in_valid          (fifo_in_valid),
                .fifo_in_stall          (stall[gi]),
                .fifo_in_stall_override (fifo_in_stall_override),
                .fifo_clear             (fifo_clear),
                .fifo_out               (dout[gi]),
                .fifo_out_valid         (dval[gi]),
                .fifo_out_ack           (fifo_out_ack),
                .fifo_used_slots        (used[gi]),
                .fifo_free_slots        (free[gi]),
                .fifo_hwm               (hwm[gi]),
                .fifo_overflow          (ovf[gi]),
                .fifo_underflow         (udf[gi])
            );
        end
    endgenerate

    function automatic int dep(input int i);
        return (i == 0) ? 4 : (i == 1) ? 5 : 6;
    endfunction
    function automatic int stl(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 1;
    endfunction
    function automatic bit oen(input int i);
        return i != 1;
    endfunction

    // Reference model state
    logic [DW-1:0] mq [NI][$];
    int            mhwm [NI];
    bit            movf [NI];
    bit            mudf [NI];
    bit            fresh [NI];
    bit            model_ok = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w = '0;
        for (int k = 0; k < (DW + 31) / 32; k++) w = {w[DW-33:0], $urandom()};
        return w;
    endfunction

    task automatic step(input bit vin, input bit ack, input bit clr, input bit ovr, input bit rst);
        @(negedge clk);
        fifo_in_valid          = vin;
        fifo_in                = rand_word();
        fifo_out_ack           = ack;
        fifo_clear             = clr;
        fifo_in_stall_override = ovr;
        rst_n                  = !rst;
        #1;
        for (int i = 0; i < NI; i++) begin
            int  sz;
            bit  ev, pop, acc;
            sz = mq[i].size();
            ev = sz > 0;
            if (model_ok) begin
                chk($sformatf("u%0d.valid", i), DW'(dval[i]), DW'(ev));
                chk($sformatf("u%0d.used", i), DW'(used[i]), DW'(sz));
                chk($sformatf("u%0d.free", i), DW'(free[i]), DW'(dep(i) - sz));
                chk($sformatf("u%0d.hwm", i), DW'(hwm[i]), DW'(mhwm[i]));
                chk($sformatf("u%0d.stall", i), DW'(stall[i]),
                    DW'(((dep(i) - sz) <= stl(i)) || (oen(i) && ovr)));
                chk($sformatf("u%0d.overflow", i), DW'(ovf[i]), DW'(movf[i]));
                chk($sformatf("u%0d.underflow", i), DW'(udf[i]), DW'(mudf[i]));
                if (ev) chk($sformatf("u%0d.data", i), dout[i], mq[i][0]);
                else if (fresh[i]) chk($sformatf("u%0d.data_rst", i), dout[i], '0);
            end
            pop = ev && ack;
            if (rst || clr) begin
                mq[i].delete();
                mhwm[i] = 0;
                movf[i] = 1'b0;
                mudf[i] = 1'b0;
                if (rst) fresh[i] = 1'b1;
            end else begin
                acc     = vin && (sz < dep(i) || pop);
                movf[i] = vin && !acc;
                mudf[i] = ack && !ev;
                if (pop) void'(mq[i].pop_front());
                if (acc) begin
                    mq[i].push_back(fifo_in);
                    fresh[i] = 1'b0;
                end
                if (mq[i].size() > mhwm[i]) mhwm[i] = mq[i].size();
            end
        end
        if (rst) model_ok = 1'b1;
        $display("cyc %0d rst=%0b clr=%0b vin=%0b ack=%0b ovr=%0b used=%0d/%0d/%0d", cyc, rst, clr,
                 vin, ack, ovr, used[0], used[1], used[2]);
        cyc++;
    endtask

    initial begin
        repeat (2) step(0, 0, 0, 0, 1);
        repeat (7) step(1, 0, 0, 0, 0);          // fill past every depth -> overflow
        repeat (10) step(1, 1, 0, 0, 0);         // full pass-through
        repeat (8) step(0, 1, 0, 0, 0);          // drain into underflow
        repeat (2) step(0, 1, 0, 0, 0);          // ack while empty
        step(0, 0, 1, 0, 0);                     // clear resets hwm
        repeat (10) step(1, 1, 0, 0, 0);         // streaming from empty
        step(0, 0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);                     // clear with concurrent write, override on
        repeat (2) step(0, 0, 0, 1, 0);
        repeat (6) step(1, 0, 0, 0, 0);
        repeat (6) step(1, 1, 0, 0, 0);          // pointer wrap
        repeat (6) step(0, 1, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (4) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1);                     // reset mid-operation
        repeat (3) step(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
